// File: rtl/mmc_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmc_cmd_seq : builds and bit-bangs a 48-bit MMC command frame through     |
// |   the controller register port, optionally capturing the 48-bit response. |
// |   Optional response CRC check: `define MMC_RESP_CRC_CHECK_EN              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mmc_cmd_seq #(
   parameter logic [2:0]  ADR_OE  = 3'd0,
   parameter logic [2:0]  ADR_CMD = 3'd1,
   parameter logic [2:0]  ADR_ADV = 3'd3,
   parameter int unsigned NCR_MAX = 64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic        resp_en,
   output logic        busy,
   output logic        done,
   output logic [47:0] resp,
   output logic        resp_timeout,
   output logic        resp_crc_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [2:0]  wbm_adr_o,
   output logic [7:0]  wbm_dat_o,
   input  logic [7:0]  wbm_dat_i,
   input  logic        wbm_ack_i
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_OE_ON   = 4'd1,
      S_TX_BIT  = 4'd2,
      S_TX_ADV  = 4'd3,
      S_TX_POLL = 4'd4,
      S_OE_OFF  = 4'd5,
      S_RX_ADV  = 4'd6,
      S_RX_POLL = 4'd7,
      S_RX_READ = 4'd8,
      S_FINISH  = 4'd9
   } state_t;

   localparam logic [7:0] c_ncr_last = 8'(NCR_MAX - 1);

   // CRC7, polynomial x^7 + x^3 + 1, one input bit per step
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
   endfunction

   state_t      r_state;
   logic [47:0] r_shift;
   logic [5:0]  r_bit_cnt;
   logic [6:0]  r_crc;
   logic        r_resp_en;
   logic        r_hunt;
   logic [7:0]  r_ncr;
   logic        r_busy;
   logic        r_done;
   logic [47:0] r_resp;
   logic        r_timeout;
   logic        r_cyc;
   logic        r_we;
   logic [2:0]  r_adr;
   logic [7:0]  r_dat;

   logic        w_access;
   logic        w_we;
   logic [2:0]  w_adr;
   logic [7:0]  w_dat;
   logic        w_acked;
   logic        w_rx_bit;
   logic        w_crc_phase;
   logic [2:0]  w_crc_sel;
   logic        w_tx_bit;
   logic        w_unused;

   assign w_acked     = r_cyc & wbm_ack_i;
   assign w_rx_bit    = wbm_dat_i[0];
   assign w_unused    = ^wbm_dat_i[7:1];
   // Bits 7..1 of the frame come from the CRC, which is complete once bit 8 has gone out
   assign w_crc_phase = (r_bit_cnt != 6'd0) && (r_bit_cnt < 6'd8);
   assign w_crc_sel   = r_bit_cnt[2:0] - 3'd1;
   assign w_tx_bit    = w_crc_phase ? r_crc[w_crc_sel] : r_shift[47];

   always_comb begin
      w_access = 1'b1;
      w_we     = 1'b1;
      w_adr    = ADR_CMD;
      w_dat    = 8'h00;
      case (r_state)
         S_OE_ON:   begin w_adr = ADR_OE; w_dat = 8'h02; end
         S_TX_BIT:  w_dat = {7'd0, w_tx_bit};
         S_TX_ADV:  w_adr = ADR_ADV;
         S_TX_POLL: begin w_we = 1'b0; w_adr = ADR_ADV; end
         S_OE_OFF:  w_adr = ADR_OE;
         S_RX_ADV:  w_adr = ADR_ADV;
         S_RX_POLL: begin w_we = 1'b0; w_adr = ADR_ADV; end
         S_RX_READ: w_we = 1'b0;
         default:   w_access = 1'b0;
      endcase
   end

`ifdef MMC_RESP_CRC_CHECK_EN
   logic r_crc_err;
   assign resp_crc_err = r_crc_err;
`else
   assign resp_crc_err = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_crc     <= '0;
         r_resp_en <= 1'b0;
         r_hunt    <= 1'b0;
         r_ncr     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_resp    <= '0;
         r_timeout <= 1'b0;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_adr     <= '0;
         r_dat     <= '0;
`ifdef MMC_RESP_CRC_CHECK_EN
         r_crc_err <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         // Every access state first spends one cycle with cyc low, then raises it
         if (w_access && !r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= w_we;
            r_adr <= w_adr;
            r_dat <= w_dat;
         end else if (w_acked) begin
            r_cyc <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (cmd_start) begin
                  r_shift   <= {2'b01, cmd_index, cmd_arg, 7'd0, 1'b1};
                  r_bit_cnt <= 6'd47;
                  r_crc     <= '0;
                  r_resp_en <= resp_en;
                  r_resp    <= '0;
                  r_timeout <= 1'b0;
`ifdef MMC_RESP_CRC_CHECK_EN
                  r_crc_err <= 1'b0;
`endif
                  r_busy    <= 1'b1;
                  r_state   <= S_OE_ON;
               end
            end
            S_OE_ON:  if (w_acked) r_state <= S_TX_BIT;
            S_TX_BIT: if (w_acked) r_state <= S_TX_ADV;
            S_TX_ADV: if (w_acked) r_state <= S_TX_POLL;
            S_TX_POLL: begin
               if (w_acked && w_rx_bit) begin
                  if (r_bit_cnt >= 6'd8)
                     r_crc <= crc7_step(r_crc, r_shift[47]);
                  r_shift <= {r_shift[46:0], 1'b0};
                  if (r_bit_cnt == 6'd0) begin
                     r_state <= S_OE_OFF;
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 6'd1;
                     r_state   <= S_TX_BIT;
                  end
               end
            end
            S_OE_OFF: begin
               if (w_acked) begin
                  r_hunt  <= 1'b1;
                  r_ncr   <= '0;
                  r_crc   <= '0;
                  r_state <= r_resp_en ? S_RX_ADV : S_FINISH;
               end
            end
            S_RX_ADV:  if (w_acked) r_state <= S_RX_POLL;
            S_RX_POLL: if (w_acked && w_rx_bit) r_state <= S_RX_READ;
            S_RX_READ: begin
               if (w_acked) begin
                  if (r_hunt) begin
                     if (!w_rx_bit) begin
                        r_hunt    <= 1'b0;
                        r_resp    <= {r_resp[46:0], w_rx_bit};
                        r_bit_cnt <= 6'd46;
`ifdef MMC_RESP_CRC_CHECK_EN
                        r_crc     <= crc7_step(r_crc, w_rx_bit);
`endif
                        r_state   <= S_RX_ADV;
                     end else if (r_ncr == c_ncr_last) begin
                        r_timeout <= 1'b1;
                        r_resp    <= '1;
                        r_state   <= S_FINISH;
                     end else begin
                        r_ncr   <= r_ncr + 8'd1;
                        r_state <= S_RX_ADV;
                     end
                  end else begin
                     r_resp <= {r_resp[46:0], w_rx_bit};
`ifdef MMC_RESP_CRC_CHECK_EN
                     if (r_bit_cnt >= 6'd8)
                        r_crc <= crc7_step(r_crc, w_rx_bit);
                     // r_resp[6:0] becomes resp[7:1] once this last bit is shifted in
                     if (r_bit_cnt == 6'd0)
                        r_crc_err <= (r_crc != r_resp[6:0]);
`endif
                     if (r_bit_cnt == 6'd0) begin
                        r_state <= S_FINISH;
                     end else begin
                        r_bit_cnt <= r_bit_cnt - 6'd1;
                        r_state   <= S_RX_ADV;
                     end
                  end
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign resp         = r_resp;
   assign resp_timeout = r_timeout;
   assign wbm_cyc_o    = r_cyc;
   assign wbm_stb_o    = r_cyc;
   assign wbm_we_o     = r_we;
   assign wbm_adr_o    = r_adr;
   assign wbm_dat_o    = r_dat;

endmodule
`default_nettype wire
